// File: rtl/hub75_capture_if.sv
// HUB75 panel pin bundle: the matrix driver is the master, the capture block the slave.
interface hub75_capture_if #(
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  hub_clk;
    logic                  hub_latch;
    logic                  hub_oe;
    logic [ADDR_WIDTH-1:0] hub_addr;
    logic [1:0]            hub_r;
    logic [1:0]            hub_g;
    logic [1:0]            hub_b;

    modport master (
        output hub_clk, hub_latch, hub_oe, hub_addr, hub_r, hub_g, hub_b
    );

    modport slave (
        input hub_clk, hub_latch, hub_oe, hub_addr, hub_r, hub_g, hub_b
    );
endinterface

// File: rtl/hub75_capture.sv
// HUB75 panel-side receiver: resynchronizes driver pins and replays each latched row as pixel writes.
// Define HUB75_CAPTURE_STATS_EN to add the latch_count / frame_count outputs.
module hub75_capture #(
    parameter int unsigned X_RES      = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned Y_STRIDE   = 8
) (
    input  logic           clk_48mhz,
    input  logic           reset,
    hub75_capture_if.slave hub,
    output logic           out_strobe,
    output logic [7:0]     out_x,
    output logic [7:0]     out_y,
    output logic           out_r,
    output logic           out_g,
    output logic           out_b,
    output logic           out_oe_n,
    output logic           busy,
    output logic           frame_start,
    output logic           short_row,
    output logic           overrun
`ifdef HUB75_CAPTURE_STATS_EN
    ,
    output logic [15:0]    latch_count,
    output logic [15:0]    frame_count
`endif
);
    localparam int unsigned SW = ADDR_WIDTH + 9;
    localparam int unsigned CW = $clog2(X_RES + 1);
    localparam int unsigned RW = 6 * X_RES;
    localparam logic [SW-1:0] SYNC_RST = {1'b1, {(SW - 1){1'b0}}};
    localparam logic [7:0]    X_LAST   = 8'(X_RES - 1);

    typedef enum logic [1:0] {StIdle, StLane0, StLane1} state_e;

    logic [SW-1:0]         in_raw, sync1_q, sync2_q;
    logic                  clk_prev_q, latch_prev_q;
    logic [RW-1:0]         shift_q, shift_next, hold_q;
    logic [CW-1:0]         col_cnt_q, col_next;
    logic [ADDR_WIDTH-1:0] row_addr_q, prev_addr_q, s_addr;
    logic [5:0]            sample;
    logic                  s_clk, s_latch, clk_rise, latch_rise, wrap;
    state_e                state_q;

    // Pixel entry x holds {r1,g1,b1,r0,g0,b0}; lane selects the upper or lower rgb triple.
    function automatic logic [2:0] lane_rgb(input logic [RW-1:0] row, input logic [7:0] x,
                                            input logic lane);
        return row[6 * int'(x) + (lane ? 3 : 0) +: 3];
    endfunction

    assign in_raw = {hub.hub_oe, hub.hub_latch, hub.hub_clk, hub.hub_addr,
                     hub.hub_r, hub.hub_g, hub.hub_b};

    assign out_oe_n   = sync2_q[SW-1];
    assign s_latch    = sync2_q[SW-2];
    assign s_clk      = sync2_q[SW-3];
    assign s_addr     = sync2_q[6 +: ADDR_WIDTH];
    assign sample     = {sync2_q[5], sync2_q[3], sync2_q[1], sync2_q[4], sync2_q[2], sync2_q[0]};
    assign clk_rise   = s_clk & ~clk_prev_q;
    assign latch_rise = s_latch & ~latch_prev_q;
    assign wrap       = (s_addr == '0) && (prev_addr_q == '1);

    // New samples enter at the tail so the first-shifted column ends up at x = 0.
    always_comb begin
        shift_next = shift_q;
        col_next   = col_cnt_q;
        if (clk_rise) begin
            shift_next = {sample, shift_q[RW-1:6]};
            if (col_cnt_q != CW'(X_RES)) col_next = col_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            sync1_q      <= SYNC_RST;
            sync2_q      <= SYNC_RST;
            clk_prev_q   <= 1'b0;
            latch_prev_q <= 1'b0;
            shift_q      <= '0;
            hold_q       <= '0;
            col_cnt_q    <= '0;
            row_addr_q   <= '0;
            prev_addr_q  <= '1;
            state_q      <= StIdle;
            out_strobe   <= 1'b0;
            out_x        <= '0;
            out_y        <= '0;
            out_r        <= 1'b0;
            out_g        <= 1'b0;
            out_b        <= 1'b0;
            busy         <= 1'b0;
            frame_start  <= 1'b0;
            short_row    <= 1'b0;
            overrun      <= 1'b0;
`ifdef HUB75_CAPTURE_STATS_EN
            latch_count  <= '0;
            frame_count  <= '0;
`endif
        end else begin
            sync1_q      <= in_raw;
            sync2_q      <= sync1_q;
            clk_prev_q   <= s_clk;
            latch_prev_q <= s_latch;
            shift_q      <= shift_next;
            col_cnt_q    <= col_next;
            out_strobe   <= 1'b0;
            frame_start  <= 1'b0;

            unique case (state_q)
                StLane0: begin
                    out_strobe <= 1'b1;
                    if (out_x == X_LAST) begin
                        out_x                 <= '0;
                        out_y                 <= 8'(row_addr_q) + 8'(Y_STRIDE);
                        {out_r, out_g, out_b} <= lane_rgb(hold_q, 8'd0, 1'b1);
                        state_q               <= StLane1;
                    end else begin
                        out_x                 <= out_x + 8'd1;
                        {out_r, out_g, out_b} <= lane_rgb(hold_q, out_x + 8'd1, 1'b0);
                    end
                end
                StLane1: begin
                    if (out_x == X_LAST) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        out_strobe            <= 1'b1;
                        out_x                 <= out_x + 8'd1;
                        {out_r, out_g, out_b} <= lane_rgb(hold_q, out_x + 8'd1, 1'b1);
                    end
                end
                default: ;
            endcase

            // A latch always restarts the shift row; only an idle emitter accepts the data.
            if (latch_rise) begin
                shift_q     <= '0;
                col_cnt_q   <= '0;
                prev_addr_q <= s_addr;
                if (col_next != CW'(X_RES)) short_row <= 1'b1;
                if (wrap) frame_start <= 1'b1;
                if (busy) begin
                    overrun <= 1'b1;
                end else begin
                    hold_q                <= shift_next;
                    row_addr_q            <= s_addr;
                    state_q               <= StLane0;
                    busy                  <= 1'b1;
                    out_strobe            <= 1'b1;
                    out_x                 <= '0;
                    out_y                 <= 8'(s_addr);
                    {out_r, out_g, out_b} <= lane_rgb(shift_next, 8'd0, 1'b0);
                end
`ifdef HUB75_CAPTURE_STATS_EN
                latch_count <= latch_count + 16'd1;
                if (wrap) frame_count <= frame_count + 16'd1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_hub75_capture.sv
// Self-checking bench for hub75_capture: drives HUB75 pins and checks the replayed pixel stream.
`timescale 1ns/1ps
module tb_hub75_capture;
    localparam int X_RES = 32;
    localparam int AW    = 3;
    localparam int YS    = 8;

    typedef struct packed {
        logic [2:0] c0;
        logic [2:0] c1;
    } col_t;

    logic       clk_48mhz = 1'b0;
    logic       reset = 1'b1;
    logic       out_strobe, out_r, out_g, out_b, out_oe_n, busy, frame_start, short_row, overrun;
    logic [7:0] out_x, out_y;
`ifdef HUB75_CAPTURE_STATS_EN
    logic [15:0] latch_count, frame_count;
`endif

    hub75_capture_if #(.ADDR_WIDTH(AW)) hub ();

    hub75_capture #(.X_RES(X_RES), .ADDR_WIDTH(AW), .Y_STRIDE(YS)) dut (
        .clk_48mhz   (clk_48mhz),
        .reset       (reset),
        .hub         (hub),
        .out_strobe  (out_strobe),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .out_oe_n    (out_oe_n),
        .busy        (busy),
        .frame_start (frame_start),
        .short_row   (short_row),
        .overrun     (overrun)
`ifdef HUB75_CAPTURE_STATS_EN
        ,
        .latch_count (latch_count),
        .frame_count (frame_count)
`endif
    );

    always #10 clk_48mhz = ~clk_48mhz;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat_cyc;
    logic [18:0] got[$];
    int          got_cyc[$];
    int          fs_cyc[$];
    logic [18:0] expq[$];
    col_t        sent[$];

    always @(posedge clk_48mhz) cyc <= cyc + 1;

    always @(negedge clk_48mhz) begin
        if (out_strobe === 1'b1) begin
            got.push_back({out_x, out_y, out_r, out_g, out_b});
            got_cyc.push_back(cyc);
        end
        if (frame_start === 1'b1) fs_cyc.push_back(cyc);
    end

    // Reference: the row is the last X_RES columns shifted since the previous latch, zero-filled
    // at the left; lane 0 then lane 1, lane 1 rows sit YS below.
    function automatic void build_expect(input logic [AW-1:0] addr);
        int n;
        n = sent.size();
        expq.delete();
        for (int lane = 0; lane < 2; lane++) begin
            for (int x = 0; x < X_RES; x++) begin
                int k;
                logic [2:0] c;
                k = n - X_RES + x;
                c = 3'b000;
                if (k >= 0) c = (lane == 1) ? sent[k].c1 : sent[k].c0;
                expq.push_back({8'(x), 8'(int'(addr) + lane * YS), c});
            end
        end
        sent.delete();
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_48mhz);
    endtask

    task automatic shift_col(input logic [2:0] c0, input logic [2:0] c1);
        col_t t;
        hub.hub_r = {c1[2], c0[2]};
        hub.hub_g = {c1[1], c0[1]};
        hub.hub_b = {c1[0], c0[0]};
        wait_cycles(4);
        hub.hub_clk = 1'b1;
        wait_cycles(4);
        hub.hub_clk = 1'b0;
        t.c0 = c0;
        t.c1 = c1;
        sent.push_back(t);
    endtask

    task automatic shift_random(input int ncols);
        for (int i = 0; i < ncols; i++) shift_col(3'($urandom_range(7)), 3'($urandom_range(7)));
    endtask

    task automatic pulse_latch(input logic [AW-1:0] addr);
        hub.hub_addr = addr;
        wait_cycles(1);
        hub.hub_latch = 1'b1;
        lat_cyc = cyc;
        wait_cycles(4);
        hub.hub_latch = 1'b0;
        wait_cycles(4);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            wait_cycles(1);
            n++;
        end
        checks++;
        if (n >= 300) begin
            fails++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
        wait_cycles(2);
    endtask

    task automatic test_reset();
        hub.hub_clk = 1'b0; hub.hub_latch = 1'b0; hub.hub_oe = 1'b1;
        hub.hub_addr = '0; hub.hub_r = '0; hub.hub_g = '0; hub.hub_b = '0;
        reset = 1'b1;
        wait_cycles(3);
        checks++;
        if ({out_strobe, busy, frame_start, short_row, overrun} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 00000",
                     {out_strobe, busy, frame_start, short_row, overrun});
        end
        checks++;
        if ({out_x, out_y, out_r, out_g, out_b} !== 19'h0) begin
            fails++;
            $display("FAIL reset_pixel: got %h required 0", {out_x, out_y, out_r, out_g, out_b});
        end
        checks++;
        if (out_oe_n !== 1'b1) begin
            fails++;
            $display("FAIL reset_oe: got %b required 1", out_oe_n);
        end
        reset = 1'b0;
        wait_cycles(4);
        checks++;
        if ({out_strobe, busy, short_row, overrun, out_oe_n} !== 5'b00001) begin
            fails++;
            $display("FAIL post_reset: got %b required 00001",
                     {out_strobe, busy, short_row, overrun, out_oe_n});
        end
    endtask

    task automatic test_single_row();
        sent.delete();
        for (int x = 0; x < X_RES; x++) shift_col((x % 2 == 0) ? 3'b100 : 3'b000, 3'b001);
        got.delete(); got_cyc.delete();
        pulse_latch(3'd3);
        build_expect(3'd3);
        wait_idle();
        checks++;
        if (got.size() != 2 * X_RES) begin
            fails++;
            $display("FAIL single_count: got %0d strobes required %0d", got.size(), 2 * X_RES);
        end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            checks++;
            if (got[i] !== expq[i]) begin
                fails++;
                $display("FAIL single_pixel[%0d]: got %h required %h", i, got[i], expq[i]);
            end
        end
        if (got_cyc.size() == 2 * X_RES) begin
            checks++;
            if (got_cyc[0] != lat_cyc + 3) begin
                fails++;
                $display("FAIL single_latency: first strobe cycle %0d required %0d",
                         got_cyc[0], lat_cyc + 3);
            end
            checks++;
            if (got_cyc[2 * X_RES - 1] - got_cyc[0] != 2 * X_RES - 1) begin
                fails++;
                $display("FAIL single_gapless: span %0d required %0d",
                         got_cyc[2 * X_RES - 1] - got_cyc[0], 2 * X_RES - 1);
            end
        end
        checks++;
        if ({short_row, overrun} !== 2'b00) begin
            fails++;
            $display("FAIL single_flags: got %b required 00", {short_row, overrun});
        end
    endtask

    task automatic test_random_rows();
        for (int r = 0; r < 3; r++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(7));
            shift_random(X_RES);
            got.delete();
            pulse_latch(a);
            build_expect(a);
            wait_idle();
            checks++;
            if (got.size() != expq.size()) begin
                fails++;
                $display("FAIL random_count[%0d]: got %0d required %0d", r, got.size(), expq.size());
            end
            for (int i = 0; i < got.size() && i < expq.size(); i++) begin
                checks++;
                if (got[i] !== expq[i]) begin
                    fails++;
                    $display("FAIL random_pixel[%0d][%0d]: got %h required %h",
                             r, i, got[i], expq[i]);
                end
            end
        end
    endtask

    task automatic test_short_row();
        shift_random(X_RES - 1);
        got.delete();
        pulse_latch(3'd5);
        build_expect(3'd5);
        wait_idle();
        checks++;
        if (short_row !== 1'b1) begin
            fails++;
            $display("FAIL short_flag: got %b required 1", short_row);
        end
        checks++;
        if (got.size() != expq.size()) begin
            fails++;
            $display("FAIL short_count: got %0d required %0d", got.size(), expq.size());
        end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            checks++;
            if (got[i] !== expq[i]) begin
                fails++;
                $display("FAIL short_pixel[%0d]: got %h required %h", i, got[i], expq[i]);
            end
        end
        shift_random(X_RES);
        pulse_latch(3'd2);
        build_expect(3'd2);
        wait_idle();
        checks++;
        if (short_row !== 1'b1) begin
            fails++;
            $display("FAIL short_sticky: got %b required 1", short_row);
        end
    endtask

    task automatic test_overrun();
        shift_random(X_RES);
        got.delete();
        pulse_latch(3'd1);
        build_expect(3'd1);
        wait_cycles(1);
        pulse_latch(3'd4);
        sent.delete();
        checks++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_flag: got %b required 1", overrun);
        end
        shift_random(X_RES);
        wait_idle();
        checks++;
        if (got.size() != expq.size()) begin
            fails++;
            $display("FAIL overrun_count: got %0d required %0d", got.size(), expq.size());
        end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            checks++;
            if (got[i] !== expq[i]) begin
                fails++;
                $display("FAIL overrun_pixel[%0d]: got %h required %h", i, got[i], expq[i]);
            end
        end
        got.delete();
        pulse_latch(3'd6);
        build_expect(3'd6);
        wait_idle();
        checks++;
        if (got.size() != expq.size()) begin
            fails++;
            $display("FAIL next_row_count: got %0d required %0d", got.size(), expq.size());
        end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            checks++;
            if (got[i] !== expq[i]) begin
                fails++;
                $display("FAIL next_row_pixel[%0d]: got %h required %h", i, got[i], expq[i]);
            end
        end
    endtask

    task automatic test_frame_wrap();
        int wrap_cyc;
        fs_cyc.delete();
        pulse_latch(3'd6); wait_idle();
        pulse_latch(3'd7); wait_idle();
        pulse_latch(3'd0); wrap_cyc = lat_cyc; wait_idle();
        pulse_latch(3'd1); wait_idle();
        sent.delete();
        checks++;
        if (fs_cyc.size() != 1) begin
            fails++;
            $display("FAIL frame_count: got %0d pulses required 1", fs_cyc.size());
        end else begin
            checks++;
            if (fs_cyc[0] != wrap_cyc + 3) begin
                fails++;
                $display("FAIL frame_timing: pulse cycle %0d required %0d", fs_cyc[0], wrap_cyc + 3);
            end
        end
    endtask

    task automatic test_oe();
        hub.hub_oe = 1'b0;
        wait_cycles(1);
        checks++;
        if (out_oe_n !== 1'b1) begin
            fails++;
            $display("FAIL oe_early: got %b required 1", out_oe_n);
        end
        wait_cycles(1);
        checks++;
        if (out_oe_n !== 1'b0) begin
            fails++;
            $display("FAIL oe_fall: got %b required 0", out_oe_n);
        end
        hub.hub_oe = 1'b1;
        wait_cycles(2);
        checks++;
        if (out_oe_n !== 1'b1) begin
            fails++;
            $display("FAIL oe_rise: got %b required 1", out_oe_n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        shift_random(X_RES);
        got.delete();
        pulse_latch(3'd2);
        sent.delete();
        n = 0;
        while (got.size() < 20 && n < 200) begin
            @(negedge clk_48mhz);
            #1;
            n++;
        end
        checks++;
        if (got.size() != 20) begin
            fails++;
            $display("FAIL reset_mid_reach: got %0d strobes required 20", got.size());
        end
        reset = 1'b1;
        wait_cycles(1);
        checks++;
        if ({out_strobe, busy, overrun, short_row, out_oe_n} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_mid_state: got %b required 00001",
                     {out_strobe, busy, overrun, short_row, out_oe_n});
        end
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(80);
        checks++;
        if (got.size() != 20) begin
            fails++;
            $display("FAIL reset_mid_abort: got %0d strobes required 20", got.size());
        end
        checks++;
        if ({busy, overrun, short_row, out_oe_n} !== 4'b0001) begin
            fails++;
            $display("FAIL reset_mid_after: got %b required 0001",
                     {busy, overrun, short_row, out_oe_n});
        end
    endtask

`ifdef HUB75_CAPTURE_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(3);
        pulse_latch(3'd6); wait_idle();
        pulse_latch(3'd7); wait_cycles(1);
        pulse_latch(3'd7); wait_idle();
        pulse_latch(3'd0); wait_idle();
        pulse_latch(3'd1); wait_idle();
        sent.delete();
        checks++;
        if (latch_count !== 16'd5) begin
            fails++;
            $display("FAIL stats_latch: got %0d required 5", latch_count);
        end
        checks++;
        if (frame_count !== 16'd1) begin
            fails++;
            $display("FAIL stats_frame: got %0d required 1", frame_count);
        end
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_48mhz);
        test_reset();
        test_single_row();
        test_random_rows();
        test_short_row();
        test_overrun();
        test_frame_wrap();
        test_oe();
        test_reset_mid();
`ifdef HUB75_CAPTURE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
